// File: rtl/sound_cmd_queue_pkg.sv
// Shared definitions for the main-CPU sound write stage: drain FSM encoding,
// default bus addresses and the CPU write decode helper.
package sound_cmd_queue_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StIssue  = 2'd1,
    StWaitLo = 2'd2,
    StWaitHi = 2'd3
  } drain_st_e;

  localparam logic [15:0] LATCH_AD_DFLT = 16'hF200;
  localparam logic [15:0] TRIG_AD_DFLT  = 16'hF400;

  function automatic logic wr_hit(input logic we, input logic [15:0] ad,
                                  input logic [15:0] target);
    return we && (ad == target);
  endfunction

endpackage

// File: rtl/sound_cmd_queue_if.sv
// CPU-side write bus and PSG handshake bundle for sound_cmd_queue.
// The slave modport is the queue itself; master is the CPU/PSG side.
interface sound_cmd_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [15:0]   CPUAD;
  logic [7:0]    CPUWD;
  logic          CPUWE;
  logic [7:0]    PSG_WD;
  logic          PSG_WE;
  logic          PSG_RDY;
  logic [LW-1:0] LEVEL;
  logic          OVF;

  modport master (
    output CPUAD, CPUWD, CPUWE, PSG_RDY,
    input  PSG_WD, PSG_WE, LEVEL, OVF
  );

  modport slave (
    input  CPUAD, CPUWD, CPUWE, PSG_RDY,
    output PSG_WD, PSG_WE, LEVEL, OVF
  );

endinterface

// File: rtl/sound_fifo.sv
// Small circular-buffer FIFO clocked on the falling edge of the CPU clock.
// Pointers carry one extra wrap bit so full and empty are told apart.
module sound_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign level = wptr_q - rptr_q;
  assign full  = (level == (AW + 1)'(DEPTH));
  assign empty = (level == '0);

  // A pop frees the slot the push would need, so a full FIFO still accepts it.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(negedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
  end

  assign dout = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/sound_cmd_queue.sv
// Main-CPU sound write stage: captures the sound latch, queues one byte per
// trigger write and drains the queue into the PSG using its READY handshake.
module sound_cmd_queue
  import sound_cmd_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] LATCH_AD = LATCH_AD_DFLT,
  parameter logic [15:0] TRIG_AD  = TRIG_AD_DFLT,
  parameter int unsigned RDY_TMO  = 4
) (
  input logic              CPUCL,
  input logic              RESET,
  sound_cmd_queue_if.slave bus
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam int unsigned CW = (RDY_TMO > 1) ? $clog2(RDY_TMO) : 1;

  drain_st_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    sndlt_q, sndlt_d;
  logic [7:0]    psg_wd_q, psg_wd_d;
  logic          psg_we_q, psg_we_d;
  logic          ptrg_q;
  logic          ovf_q, ovf_d;

  logic          trg, lat, push, pop, full, empty;
  logic [7:0]    head;
  logic [LW-1:0] level;

  assign trg  = wr_hit(bus.CPUWE, bus.CPUAD, TRIG_AD);
  assign lat  = wr_hit(bus.CPUWE, bus.CPUAD, LATCH_AD);
  // One push per CPU write cycle, however long the strobe is held.
  assign push = trg && !ptrg_q;

  sound_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (CPUCL),
    .rst   (RESET),
    .push  (push),
    .pop   (pop),
    .din   (sndlt_q),
    .dout  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    sndlt_d = sndlt_q;
    ovf_d   = ovf_q;
    if (lat) sndlt_d = bus.CPUWD;
    if (push && full && !pop) ovf_d = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    psg_wd_d = psg_wd_q;
    psg_we_d = 1'b0;
    pop      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop      = 1'b1;
          psg_wd_d = head;
          psg_we_d = 1'b1;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWaitLo;
      end
      StWaitLo: begin
        // A PSG that never drops READY is treated as having taken the byte.
        if (!bus.PSG_RDY) begin
          state_d = StWaitHi;
        end else if (cnt_q == CW'(RDY_TMO - 1)) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitHi: begin
        if (bus.PSG_RDY) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(negedge CPUCL or posedge RESET) begin
    if (RESET) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      sndlt_q  <= 8'h00;
      psg_wd_q <= 8'h00;
      psg_we_q <= 1'b0;
      ptrg_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sndlt_q  <= sndlt_d;
      psg_wd_q <= psg_wd_d;
      psg_we_q <= psg_we_d;
      ptrg_q   <= trg;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.PSG_WD = psg_wd_q;
  assign bus.PSG_WE = psg_we_q;
  assign bus.LEVEL  = level;
  assign bus.OVF    = ovf_q;

endmodule

// File: tb/tb_sound_cmd_queue.sv
// Bench for sound_cmd_queue: a queue-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_sound_cmd_queue;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned RDY_TMO = 4;
  localparam logic [15:0] LATCH   = 16'hF200;
  localparam logic [15:0] TRIG    = 16'hF400;

  logic CPUCL = 1'b0;
  logic RESET;

  sound_cmd_queue_if #(.DEPTH(DEPTH)) bus ();

  sound_cmd_queue #(
    .DEPTH    (DEPTH),
    .LATCH_AD (LATCH),
    .TRIG_AD  (TRIG),
    .RDY_TMO  (RDY_TMO)
  ) dut (
    .CPUCL (CPUCL),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CPUCL = ~CPUCL;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_en = 0;

  // Reference model state
  byte unsigned m_q[$];
  byte unsigned m_latch, m_wd;
  bit           m_we, m_ovf, m_ptrg, m_busy, m_seen_lo;
  int           m_age;

  // Strobes observed on the DUT
  byte unsigned dut_log[$];
  int           dut_t[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_latch = 8'h00; m_wd = 8'h00; m_we = 0; m_ovf = 0; m_ptrg = 0;
    m_busy = 0; m_seen_lo = 0; m_age = 0;
  endtask

  // One CPUCL falling edge: the PSG engine takes the head when free, holds
  // one dead cycle, then waits for READY low-then-high or RDY_TMO cycles.
  task automatic model_step();
    bit trg, popping;
    int sz;
    trg     = bus.CPUWE && (bus.CPUAD == TRIG);
    sz      = m_q.size();
    popping = 0;
    m_we    = 0;
    if (!m_busy) begin
      if (sz != 0) begin
        m_wd = m_q.pop_front();
        m_we = 1; m_busy = 1; m_age = 0; m_seen_lo = 0; popping = 1;
      end
    end else begin
      m_age++;
      if (m_age >= 2) begin
        if (m_seen_lo) begin
          if (bus.PSG_RDY) m_busy = 0;
        end else if (!bus.PSG_RDY) begin
          m_seen_lo = 1;
        end else if (m_age - 2 == RDY_TMO - 1) begin
          m_busy = 0;
        end
      end
    end
    if (trg && !m_ptrg) begin
      if (sz < DEPTH || popping) m_q.push_back(m_latch);
      else m_ovf = 1;
    end
    if (bus.CPUWE && bus.CPUAD == LATCH) m_latch = bus.CPUWD;
    m_ptrg = trg;
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge CPUCL or posedge RESET);
      if (RESET) model_reset();
      else model_step();
    end
  end

  // Compare on the rising edge, mid-way between DUT update edges.
  initial begin
    forever begin
      @(posedge CPUCL);
      cyc++;
      if (chk_en) begin
        chk("PSG_WE", bus.PSG_WE, m_we);
        chk("PSG_WD", bus.PSG_WD, m_wd);
        chk("LEVEL", bus.LEVEL, m_q.size());
        chk("OVF", bus.OVF, m_ovf);
        if (bus.PSG_WE === 1'b1) begin
          dut_log.push_back(bus.PSG_WD);
          dut_t.push_back(cyc);
        end
      end
    end
  end

  task automatic cpu_wr(input logic [15:0] ad, input logic [7:0] d);
    bus.CPUAD = ad; bus.CPUWD = d; bus.CPUWE = 1'b1;
    @(posedge CPUCL);
    bus.CPUWE = 1'b0; bus.CPUAD = 16'h0000;
  endtask

  task automatic snd(input logic [7:0] b);
    cpu_wr(LATCH, b);
    cpu_wr(TRIG, 8'h00);
  endtask

  task automatic clr_log();
    dut_log.delete();
    dut_t.delete();
  endtask

  initial begin
    byte unsigned burst[4];
    burst = '{8'h80, 8'h01, 8'h90, 8'h9F};
    RESET = 1'b1;
    bus.CPUAD = 16'h0000; bus.CPUWD = 8'h00; bus.CPUWE = 1'b0; bus.PSG_RDY = 1'b1;
    repeat (2) @(posedge CPUCL);
    #1;
    chk("reset PSG_WE", bus.PSG_WE, 0);
    chk("reset PSG_WD", bus.PSG_WD, 8'h00);
    chk("reset LEVEL", bus.LEVEL, 0);
    chk("reset OVF", bus.OVF, 0);
    chk_en = 1;
    @(posedge CPUCL);
    RESET = 1'b0;
    repeat (2) @(posedge CPUCL);

    // Single write, PSG busy for 32 cycles
    clr_log();
    snd(8'h9F);
    #1;
    chk("single LEVEL after trigger", bus.LEVEL, 1);
    chk("single no early strobe", bus.PSG_WE, 0);
    @(posedge CPUCL); #1;
    chk("single strobe at N+1", bus.PSG_WE, 1);
    chk("single byte", bus.PSG_WD, 8'h9F);
    chk("single LEVEL drained", bus.LEVEL, 0);
    @(posedge CPUCL); #1;
    chk("single strobe one cycle", bus.PSG_WE, 0);
    bus.PSG_RDY = 1'b0;
    repeat (32) @(posedge CPUCL);
    bus.PSG_RDY = 1'b1;
    repeat (4) @(posedge CPUCL);
    chk("single strobe count", dut_log.size(), 1);
    chk("single OVF", bus.OVF, 0);

    // Burst while PSG is busy
    clr_log();
    bus.PSG_RDY = 1'b0;
    foreach (burst[i]) snd(burst[i]);
    #1;
    chk("burst LEVEL peak", bus.LEVEL, 3);
    chk("burst one issued", dut_log.size(), 1);
    bus.PSG_RDY = 1'b1;
    repeat (40) @(posedge CPUCL);
    chk("burst count", dut_log.size(), 4);
    foreach (burst[i]) if (i < dut_log.size()) chk("burst order", dut_log[i], burst[i]);
    chk("burst OVF", bus.OVF, 0);

    // Overflow with PSG stuck busy
    clr_log();
    bus.PSG_RDY = 1'b0;
    for (int i = 0; i < 6; i++) snd(8'hA0 + 8'(i));
    #1;
    chk("ovf LEVEL full", bus.LEVEL, 4);
    chk("ovf flag", bus.OVF, 1);
    chk("ovf one issued", dut_log.size(), 1);
    bus.PSG_RDY = 1'b1;
    repeat (50) @(posedge CPUCL);
    chk("ovf drained count", dut_log.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < dut_log.size()) chk("ovf byte", dut_log[i], 8'hA0 + i);
    chk("ovf sticky", bus.OVF, 1);
    #2 RESET = 1'b1;
    #1 chk("ovf cleared by reset", bus.OVF, 0);
    @(posedge CPUCL);
    RESET = 1'b0;
    @(posedge CPUCL);

    // Wide strobe then a re-raised strobe
    clr_log();
    cpu_wr(LATCH, 8'hC3);
    bus.CPUAD = TRIG; bus.CPUWE = 1'b1;
    repeat (3) @(posedge CPUCL);
    #1;
    chk("wide one push", dut_log.size() + bus.LEVEL, 1);
    bus.CPUWE = 1'b0;
    @(posedge CPUCL);
    bus.CPUWE = 1'b1;
    @(posedge CPUCL);
    bus.CPUWE = 1'b0; bus.CPUAD = 16'h0000;
    repeat (30) @(posedge CPUCL);
    chk("wide second push", dut_log.size(), 2);
    if (dut_log.size() == 2) chk("wide byte", dut_log[1], 8'hC3);

    // Timeout pacing with READY tied high
    clr_log();
    snd(8'h11); snd(8'h22); snd(8'h33);
    repeat (40) @(posedge CPUCL);
    chk("tmo count", dut_log.size(), 3);
    if (dut_t.size() == 3) begin
      chk("tmo spacing 1", dut_t[1] - dut_t[0], RDY_TMO + 2);
      chk("tmo spacing 2", dut_t[2] - dut_t[1], RDY_TMO + 2);
      chk("tmo last byte", dut_log[2], 8'h33);
    end

    // Reset in the middle of a handshake
    bus.PSG_RDY = 1'b0;
    snd(8'h44); snd(8'h55); snd(8'h66);
    #1;
    chk("mid LEVEL before reset", bus.LEVEL, 2);
    #1 RESET = 1'b1;
    #1;
    chk("mid PSG_WE", bus.PSG_WE, 0);
    chk("mid PSG_WD", bus.PSG_WD, 8'h00);
    chk("mid LEVEL", bus.LEVEL, 0);
    chk("mid OVF", bus.OVF, 0);
    @(posedge CPUCL);
    RESET = 1'b0;
    clr_log();
    bus.PSG_RDY = 1'b1;
    repeat (20) @(posedge CPUCL);
    chk("mid no stale byte", dut_log.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sound_cmd_queue.md
# sound_cmd_queue

Main-CPU-side sound write stage for the Green Beret / Rush'n Attack core. Sits directly downstream of the main CPU bus (Z80 address, write data, qualified write strobe):
- captures writes to the sound data latch and the sound trigger address;
- queues triggered bytes in a small FIFO;
- drains them one at a time into the SN76489-class PSG core using its READY handshake.

This keeps back-to-back CPU PSG writes from being lost while the PSG is busy.

## Interface
Parameters:
- DEPTH, 4, FIFO entries (power of two, 2..16)
- LATCH_AD, 16'hF200, CPU address of sound data latch
- TRIG_AD, 16'hF400, CPU address of PSG write trigger
- RDY_TMO, 4, cycles to wait for PSG_RDY to fall before treating a write as complete

Ports:
- CPUCL  in  1  CPU clock; all state updates on negative edge
- RESET  in  1  asynchronous, active-high reset
- CPUAD  in  16  CPU address
- CPUWD  in  8  CPU write data
- CPUWE  in  1  qualified memory write (MREQ & WR)
- PSG_WD  out  8  byte to PSG
- PSG_WE  out  1  one-cycle PSG write strobe
- PSG_RDY  in  1  PSG ready (low while PSG is processing a write)
- LEVEL  out  $clog2(DEPTH)+1  FIFO occupancy
- OVF  out  1  sticky overflow flag

## Operation
- Latch: on a sampled cycle with CPUWE & CPUAD==LATCH_AD, SNDLT <= CPUWD. The latch holds its value until the next such write.
- Trigger detection:
  - TRG = CPUWE & CPUAD==TRIG_AD, registered as pTRG.
  - A push occurs only when TRG & ~pTRG, i.e. one push per CPU write cycle regardless of strobe width.
  - The data pushed is the current SNDLT; CPUWD is ignored on trigger.
- FIFO:
  - Circular buffer with read/write pointers one bit wider than the index.
  - LEVEL = wptr - rptr.
  - Push when full with no same-cycle pop: byte is dropped, OVF <= 1. OVF clears only on RESET.
  - Push and pop in the same cycle: both succeed, LEVEL unchanged. This includes the full case, where the push is accepted because a pop is occurring.
- Drain FSM:
  - IDLE: if LEVEL!=0, then pop, PSG_WD <= head, PSG_WE <= 1, go to ISSUE.
  - ISSUE: PSG_WE <= 0, clear timeout counter, go to WAIT_LO.
  - WAIT_LO: if ~PSG_RDY, go to WAIT_HI. Otherwise increment the counter; when the counter reaches RDY_TMO-1, go to IDLE (PSG never signalled busy).
  - WAIT_HI: when PSG_RDY=1, go to IDLE.
- PSG_WD holds the last issued byte between writes.

## Timing
- Reset values: PSG_WE=0, PSG_WD=8'h00, LEVEL=0, OVF=0, SNDLT=8'h00, pTRG=0, FSM=IDLE. Reset takes effect immediately and asynchronously, including mid-handshake; the in-flight byte and all queued bytes are discarded.
- Trigger to PSG with an empty FIFO and IDLE state:
  - Trigger sampled at edge N, so LEVEL=1 after edge N.
  - PSG_WE=1 after edge N+1 and low after edge N+2.
  - LEVEL returns to 0 after edge N+1.
- PSG_WE is high for exactly one CPUCL cycle per byte. No two strobes come closer than 3 cycles apart (ISSUE + WAIT_LO minimum + IDLE).
- A trigger strobe held for k cycles produces exactly one push. A strobe that drops and rises again produces a second push.
- A latch write and a trigger sampled on consecutive edges: the push uses the new latch value.
- Pointers wrap modulo 2·DEPTH; there is no dependence on absolute pointer value.

## Structure
- Shared package: FSM state encoding (IDLE, ISSUE, WAIT_LO, WAIT_HI) and the default address constants LATCH_AD and TRIG_AD, reused by the address decode in the top level.
- One sub-module, sound_fifo: a parameterised synchronous FIFO with push, pop, dout, level, full and empty outputs. Edge detection, latch and FSM stay in sound_cmd_queue.

## Test plan
- Single write: latch 8'h9F, trigger once with PSG_RDY dropping 1 cycle after PSG_WE for 32 cycles. Expect exactly one PSG_WE with PSG_WD=8'h9F, 2 edges after the trigger; LEVEL back to 0; OVF=0.
- Burst: latch and trigger 8'h80, 8'h01, 8'h90, 8'h9F back-to-back while PSG_RDY is held low. Expect LEVEL to reach 3, then all four bytes issued in order after PSG_RDY rises, and OVF=0.
- Overflow: with DEPTH=4 and PSG_RDY stuck low, issue 6 triggers. Expect 1 byte issued, 4 queued, 1 dropped, and OVF=1 held until RESET.
- Wide strobe: hold the trigger address with CPUWE for 3 cycles. Expect exactly 1 push. Then drop and re-raise the strobe: expect a second push.
- Timeout: PSG_RDY tied high. Expect each queued byte to be issued every RDY_TMO+2 cycles (6 with the default of 4), with no hang.
- Reset mid-operation: assert RESET while in WAIT_HI with LEVEL=2. Expect PSG_WE=0, LEVEL=0, OVF=0 and FSM=IDLE immediately. After release, no stale byte is issued.
